// File: rtl/rv_enc_pkg.sv
// RV32I encoder shared types: opcode/funct3 constants, format enum, request bundle
// and immediate scatter helpers used by the instruction-memory loader.
package rv_enc_pkg;

    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_OP     = 5'b01100;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_SW      = 3'b010;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic [4:0]  opc;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    // Each helper returns the immediate scattered into its instruction-word bit positions.
    function automatic logic [31:0] enc_imm_i(input logic [11:0] imm);
        return {imm[11:0], 20'b0};
    endfunction

    function automatic logic [31:0] enc_imm_s(input logic [11:0] imm);
        return {imm[11:5], 13'b0, imm[4:0], 7'b0};
    endfunction

    function automatic logic [31:0] enc_imm_b(input logic [12:1] imm);
        return {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
    endfunction

    function automatic logic [31:0] enc_imm_u(input logic [31:12] imm);
        return {imm[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] enc_imm_j(input logic [20:1] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
    endfunction

endpackage

// File: rtl/insn_encoder_loader_if.sv
// Field-bundle request and loader write port of the instruction encoder.
interface insn_encoder_loader_if #(parameter int unsigned ADDR_W = 32);
    logic              i_req_vld;
    logic              o_req_rdy;
    logic [4:0]        i_opc;
    logic [2:0]        i_funct3;
    logic              i_alt;
    logic [4:0]        i_rd;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [31:0]       i_imm;
    logic              o_wr_en;
    logic              i_wr_rdy;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;

    modport slave (
        input  i_req_vld, i_opc, i_funct3, i_alt, i_rd, i_rs1, i_rs2, i_imm, i_wr_rdy,
        output o_req_rdy, o_wr_en, o_wr_addr, o_wr_data
    );

    modport master (
        output i_req_vld, i_opc, i_funct3, i_alt, i_rd, i_rs1, i_rs2, i_imm, i_wr_rdy,
        input  o_req_rdy, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head word is read straight from the storage registers.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/insn_encoder_loader.sv
// RV32I field-bundle encoder: one-entry encode stage with legality check, word FIFO,
// and an auto-incrementing byte address for the instruction-memory loader.
module insn_encoder_loader
    import rv_enc_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clr,
    insn_encoder_loader_if.slave          bus,
    output logic                          o_err,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);
    enc_req_t          req;
    fmt_e              fmt;
    logic              legal;
    logic [31:0]       word;
    logic              enc_vld;
    logic [31:0]       enc_word;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              push_ok;
    logic              accept;
    logic [ADDR_W-1:0] addr;

    assign pop           = !empty && bus.i_wr_rdy;
    assign push_ok       = !full || pop;
    assign push          = enc_vld && push_ok;
    assign bus.o_req_rdy = !enc_vld || push_ok;
    assign accept        = bus.i_req_vld && bus.o_req_rdy;
    assign bus.o_wr_en   = !empty;
    assign bus.o_wr_addr = addr;

    always_comb begin
        req.opc    = bus.i_opc;
        req.funct3 = bus.i_funct3;
        req.alt    = bus.i_alt;
        req.rd     = bus.i_rd;
        req.rs1    = bus.i_rs1;
        req.rs2    = bus.i_rs2;
        req.imm    = bus.i_imm;
    end

    always_comb begin
        fmt   = FMT_I;
        legal = 1'b1;
        case (req.opc)
            OPCODE_LOAD:   legal = !(req.funct3 inside {3'b011, 3'b110, 3'b111});
            OPCODE_OP_IMM: begin
                fmt   = (req.funct3 inside {FUNCT3_SLL, FUNCT3_SRL_SRA}) ? FMT_SH : FMT_I;
                legal = !req.alt || (req.funct3 == FUNCT3_SRL_SRA);
            end
            OPCODE_AUIPC,
            OPCODE_LUI:    fmt = FMT_U;
            OPCODE_STORE: begin
                fmt   = FMT_S;
                legal = (req.funct3 <= FUNCT3_SW);
            end
            OPCODE_OP: begin
                fmt   = FMT_R;
                legal = !req.alt || (req.funct3 inside {FUNCT3_ADD_SUB, FUNCT3_SRL_SRA});
            end
            OPCODE_BRANCH: begin
                fmt   = FMT_B;
                legal = !(req.funct3 inside {3'b010, 3'b011});
            end
            OPCODE_JALR:   legal = (req.funct3 == 3'b000);
            OPCODE_JAL:    fmt = FMT_J;
            default:       legal = 1'b0;
        endcase
    end

    // Fields not used by a format are simply never OR-ed in, so they encode as zero.
    always_comb begin
        logic [31:0] f_opc, f_rd, f_f3, f_rs1, f_rs2, f_alt;
        f_opc = {25'b0, req.opc, 2'b11};
        f_rd  = {20'b0, req.rd, 7'b0};
        f_f3  = {17'b0, req.funct3, 12'b0};
        f_rs1 = {12'b0, req.rs1, 15'b0};
        f_rs2 = {7'b0, req.rs2, 20'b0};
        f_alt = req.alt ? 32'h4000_0000 : 32'h0;
        word  = f_opc;
        case (fmt)
            FMT_R:   word = f_opc | f_rd | f_f3 | f_rs1 | f_rs2 | f_alt;
            FMT_I:   word = f_opc | f_rd | f_f3 | f_rs1 | enc_imm_i(req.imm[11:0]);
            FMT_SH:  word = f_opc | f_rd | f_f3 | f_rs1 | f_alt | {7'b0, req.imm[4:0], 20'b0};
            FMT_S:   word = f_opc | f_f3 | f_rs1 | f_rs2 | enc_imm_s(req.imm[11:0]);
            FMT_B:   word = f_opc | f_f3 | f_rs1 | f_rs2 | enc_imm_b(req.imm[12:1]);
            FMT_U:   word = f_opc | f_rd | enc_imm_u(req.imm[31:12]);
            FMT_J:   word = f_opc | f_rd | enc_imm_j(req.imm[20:1]);
            default: word = f_opc;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            enc_vld  <= 1'b0;
            enc_word <= '0;
            o_err    <= 1'b0;
            addr     <= BASE_ADDR;
        end else if (i_clr) begin
            enc_vld  <= 1'b0;
            enc_word <= '0;
            o_err    <= 1'b0;
            addr     <= BASE_ADDR;
        end else begin
            // An illegal accept still frees the stage once its current word has moved on.
            if (accept && legal) begin
                enc_vld  <= 1'b1;
                enc_word <= word;
            end else if (push) begin
                enc_vld  <= 1'b0;
            end
            if (accept && !legal) o_err <= 1'b1;
            if (pop) addr <= addr + ADDR_W'(4);
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (i_clr),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (bus.o_wr_data),
        .full  (full),
        .empty (empty),
        .count (o_count)
    );
endmodule

// File: tb/tb_insn_encoder_loader.sv
// Directed-vector bench for insn_encoder_loader: encodings, latency, backpressure,
// illegal bundles, flush and asynchronous reset.
module tb_insn_encoder_loader;

    logic       i_clk;
    logic       i_rst;
    logic       i_clr;
    logic       o_err;
    logic [2:0] o_count;

    int passed;
    int total;

    insn_encoder_loader_if #(.ADDR_W(32)) bus ();

    insn_encoder_loader #(
        .FIFO_DEPTH (4),
        .ADDR_W     (32),
        .BASE_ADDR  (32'h0)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_clr),
        .bus     (bus),
        .o_err   (o_err),
        .o_count (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];
    vec_t bad [3];

    function automatic vec_t mk(input logic [4:0] opc, input logic [2:0] f3, input logic alt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] exp);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.alt = alt; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input vec_t v);
        bus.i_opc    = v.opc;
        bus.i_funct3 = v.f3;
        bus.i_alt    = v.alt;
        bus.i_rd     = v.rd;
        bus.i_rs1    = v.rs1;
        bus.i_rs2    = v.rs2;
        bus.i_imm    = v.imm;
    endtask

    // Offer a bundle at a falling edge and hold it until the rising edge that accepts it.
    task automatic send(input vec_t v);
        int n;
        @(negedge i_clk);
        drive(v);
        bus.i_req_vld = 1'b1;
        n = 0;
        while (!bus.o_req_rdy && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("accept_wait", bus.o_req_rdy, 1);
        @(posedge i_clk);
        #1;
        bus.i_req_vld = 1'b0;
    endtask

    initial begin
        int k;
        passed = 0;
        total  = 0;

        tbl[0] = mk(5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093); // ADDI
        tbl[1] = mk(5'b01100, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3); // SUB
        tbl[2] = mk(5'b01101, 3'b011, 1'b0, 5'd5, 5'd1, 5'd0, 32'h12345000,  32'h123452B7); // LUI
        tbl[3] = mk(5'b11000, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8,  32'hFE208CE3); // BEQ -8
        tbl[4] = mk(5'b01000, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4,         32'h0020A223); // SW
        tbl[5] = mk(5'b00100, 3'b101, 1'b1, 5'd2, 5'd3, 5'd0, 32'd7,         32'h4071D113); // SRAI
        tbl[6] = mk(5'b11011, 3'b111, 1'b0, 5'd1, 5'd7, 5'd9, 32'h00000800,  32'h001000EF); // JAL
        tbl[7] = mk(5'b00000, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC,  32'hFFC12283); // LW -4
        tbl[8] = mk(5'b00101, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'hFFFFF123,  32'hFFFFF197); // AUIPC
        tbl[9] = mk(5'b11001, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,         32'h00008067); // JALR
        bad[0] = mk(5'b11111, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,         32'h0);
        bad[1] = mk(5'b00000, 3'b111, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,         32'h0);
        bad[2] = mk(5'b01100, 3'b001, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0,         32'h0);

        i_rst = 1'b0;
        i_clr = 1'b0;
        bus.i_req_vld = 1'b0;
        bus.i_wr_rdy  = 1'b1;
        drive(tbl[0]);
        #1 i_rst = 1'b1;
        #1;
        check("rst_wr_en",   bus.o_wr_en,   0);
        check("rst_wr_data", bus.o_wr_data, 32'h0);
        check("rst_err",     o_err,         0);
        check("rst_count",   o_count,       0);
        check("rst_addr",    bus.o_wr_addr, 32'h0);
        check("rst_req_rdy", bus.o_req_rdy, 1);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // Encodings and two-cycle latency, one word at a time.
        for (int i = 0; i < 10; i++) begin
            send(tbl[i]);
            check("lat_not_yet", bus.o_wr_en, 0);
            @(posedge i_clk);
            #1;
            check("lat_wr_en", bus.o_wr_en,   1);
            check("enc_data",  bus.o_wr_data, tbl[i].exp);
            check("enc_addr",  bus.o_wr_addr, 32'(4 * i));
            @(posedge i_clk);
            #1;
        end

        // Backpressure: FIFO plus encode stage absorb five bundles.
        bus.i_wr_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(tbl[i]);
        check("bp_req_rdy", bus.o_req_rdy, 0);
        check("bp_count",   o_count,       4);
        check("bp_head",    bus.o_wr_data, tbl[0].exp);
        check("bp_addr",    bus.o_wr_addr, 32'd40);
        repeat (3) @(posedge i_clk);
        #1;
        check("bp_hold_data", bus.o_wr_data, tbl[0].exp);
        check("bp_hold_addr", bus.o_wr_addr, 32'd40);
        check("bp_hold_en",   bus.o_wr_en,   1);
        @(negedge i_clk);
        drive(tbl[5]);
        bus.i_req_vld = 1'b1;
        check("bp_blocked", bus.o_req_rdy, 0);
        @(posedge i_clk);
        #1;
        check("bp_count_held", o_count, 4);
        @(negedge i_clk);
        bus.i_wr_rdy = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            if (bus.o_wr_en) begin
                check("drain_data", bus.o_wr_data, tbl[k].exp);
                check("drain_addr", bus.o_wr_addr, 32'(40 + 4 * k));
                k++;
            end
            @(posedge i_clk);
            #1;
            bus.i_req_vld = 1'b0;
            @(negedge i_clk);
        end
        check("drain_words", k, 6);

        // Illegal bundles: accepted, dropped, sticky error.
        check("err_before", o_err, 0);
        send(bad[0]);
        check("err_bad_opc", o_err, 1);
        send(bad[1]);
        check("err_load_f3", o_err, 1);
        send(bad[2]);
        repeat (3) @(posedge i_clk);
        #1;
        check("bad_count",  o_count,       0);
        check("bad_wr_en",  bus.o_wr_en,   0);
        check("bad_addr",   bus.o_wr_addr, 32'd64);
        check("err_sticky", o_err,         1);

        // Flush beats a bundle offered in the same cycle.
        bus.i_wr_rdy = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        @(posedge i_clk);
        #1;
        check("pre_clr_count", o_count, 2);
        @(negedge i_clk);
        i_clr = 1'b1;
        drive(tbl[2]);
        bus.i_req_vld = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr = 1'b0;
        bus.i_req_vld = 1'b0;
        check("clr_err",   o_err,         0);
        check("clr_count", o_count,       0);
        check("clr_wr_en", bus.o_wr_en,   0);
        check("clr_addr",  bus.o_wr_addr, 32'h0);
        repeat (3) @(posedge i_clk);
        #1;
        check("clr_dropped", o_count, 0);

        // Asynchronous reset while words are streaming out.
        send(bad[0]);
        send(tbl[0]);
        send(tbl[1]);
        send(tbl[2]);
        @(posedge i_clk);
        #1;
        check("pre_rst_count", o_count, 3);
        @(negedge i_clk);
        bus.i_wr_rdy = 1'b1;
        @(posedge i_clk);
        #1;
        check("pre_rst_addr", bus.o_wr_addr, 32'd4);
        check("pre_rst_err",  o_err,         1);
        #1 i_rst = 1'b1;
        #1;
        check("arst_wr_en",   bus.o_wr_en,   0);
        check("arst_wr_data", bus.o_wr_data, 32'h0);
        check("arst_count",   o_count,       0);
        check("arst_err",     o_err,         0);
        check("arst_addr",    bus.o_wr_addr, 32'h0);
        check("arst_req_rdy", bus.o_req_rdy, 1);
        @(negedge i_clk);
        i_rst = 1'b0;
        send(tbl[0]);
        @(posedge i_clk);
        #1;
        check("post_rst_en",   bus.o_wr_en,   1);
        check("post_rst_data", bus.o_wr_data, 32'h00500093);
        check("post_rst_addr", bus.o_wr_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
